// File: rtl/matrix_store.sv
// Slot-based matrix storage: allocation FSM with zero-fill, bounds-checked element
// writes, and a registered element/metadata read port.
module matrix_store #(
    parameter int SLOTS   = 8,
    parameter int MAX_DIM = 5,
    parameter int DW      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             alloc_req,
    input  logic [3:0]       alloc_m,
    input  logic [3:0]       alloc_n,
    output logic             alloc_valid,
    output logic [6:0]       alloc_id,
    output logic             alloc_err,
    output logic             busy,
    input  logic             mem_we,
    input  logic [6:0]       mem_id,
    input  logic [3:0]       mem_row,
    input  logic [3:0]       mem_col,
    input  logic [DW-1:0]    mem_data,
    output logic             wr_err,
    input  logic             rd_req,
    input  logic [6:0]       rd_id,
    input  logic [3:0]       rd_row,
    input  logic [3:0]       rd_col,
    output logic             rd_valid,
    output logic [DW-1:0]    rd_data,
    output logic [3:0]       rd_m,
    output logic [3:0]       rd_n,
    output logic             rd_err,
    output logic [SLOTS-1:0] slot_valid
);
    localparam int SW    = (SLOTS > 1) ? $clog2(SLOTS) : 1;
    localparam int WORDS = MAX_DIM * MAX_DIM;
    localparam int CW    = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int DEPTH = SLOTS * WORDS;
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {IDLE, CLEAR, GRANT} state_t;

    state_t            state_q;
    logic [SW-1:0]     ptr_q;
    logic [SW-1:0]     tgt_q;
    logic [3:0]        am_q;
    logic [3:0]        an_q;
    logic [CW-1:0]     clr_q;
    logic [SLOTS-1:0]  valid_q;
    logic [3:0]        m_q [SLOTS];
    logic [3:0]        n_q [SLOTS];
    logic [DW-1:0]     mem [DEPTH];

    logic              alloc_valid_q;
    logic [6:0]        alloc_id_q;
    logic              alloc_err_q;
    logic              busy_q;
    logic              wr_err_q;
    logic              rd_valid_q;
    logic [DW-1:0]     rd_data_q;
    logic [3:0]        rd_m_q;
    logic [3:0]        rd_n_q;
    logic              rd_err_q;

    function automatic logic [9:0] word_addr(input logic [6:0] id,
                                             input logic [3:0] row,
                                             input logic [3:0] col);
        return 10'(id) * 10'(WORDS) + 10'(row) * 10'(MAX_DIM) + 10'(col);
    endfunction

    logic [SW-1:0] wr_slot;
    logic [SW-1:0] rd_slot;
    logic [9:0]    wr_addr;
    logic [9:0]    rd_addr;
    logic [AW-1:0] clr_addr;
    logic          wr_ok;
    logic          rd_ok;
    logic          dims_ok;
    logic [DW-1:0] rd_word;

    assign wr_slot  = mem_id[SW-1:0];
    assign rd_slot  = rd_id[SW-1:0];
    assign wr_addr  = word_addr(mem_id, mem_row, mem_col);
    assign rd_addr  = word_addr(rd_id, rd_row, rd_col);
    assign clr_addr = AW'(tgt_q) * AW'(WORDS) + AW'(clr_q);

    // The address range guard is redundant with the slot/row/col checks but keeps
    // the array index provably in bounds.
    assign wr_ok = mem_we && (mem_id < 7'(SLOTS)) && valid_q[wr_slot]
                   && (mem_row < m_q[wr_slot]) && (mem_col < n_q[wr_slot])
                   && (wr_addr < 10'(DEPTH));
    assign rd_ok = rd_req && (rd_id < 7'(SLOTS)) && valid_q[rd_slot]
                   && (rd_row < m_q[rd_slot]) && (rd_col < n_q[rd_slot])
                   && (rd_addr < 10'(DEPTH));
    assign dims_ok = (alloc_m != 4'd0) && (alloc_m <= 4'(MAX_DIM))
                     && (alloc_n != 4'd0) && (alloc_n <= 4'(MAX_DIM));
    assign rd_word = mem[rd_addr[AW-1:0]];

    // Zero-fill port and external write port never hit the same slot: the slot
    // being cleared is invalid, so external writes to it are rejected.
    always_ff @(posedge clk) begin
        if (state_q == CLEAR) mem[clr_addr] <= '0;
        if (wr_ok) mem[wr_addr[AW-1:0]] <= mem_data;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= IDLE;
            ptr_q         <= '0;
            tgt_q         <= '0;
            am_q          <= '0;
            an_q          <= '0;
            clr_q         <= '0;
            valid_q       <= '0;
            alloc_valid_q <= 1'b0;
            alloc_id_q    <= '0;
            alloc_err_q   <= 1'b0;
            busy_q        <= 1'b0;
            wr_err_q      <= 1'b0;
            rd_valid_q    <= 1'b0;
            rd_data_q     <= '0;
            rd_m_q        <= '0;
            rd_n_q        <= '0;
            rd_err_q      <= 1'b0;
        end else begin
            alloc_valid_q <= 1'b0;
            alloc_err_q   <= 1'b0;
            busy_q        <= (state_q != IDLE);
            wr_err_q      <= mem_we && !wr_ok;
            rd_valid_q    <= rd_req;
            rd_err_q      <= rd_req && !rd_ok;
            rd_data_q     <= rd_ok ? rd_word : '0;
            rd_m_q        <= rd_ok ? m_q[rd_slot] : '0;
            rd_n_q        <= rd_ok ? n_q[rd_slot] : '0;
            case (state_q)
                IDLE: begin
                    if (alloc_req && !busy_q) begin
                        if (dims_ok) begin
                            am_q           <= alloc_m;
                            an_q           <= alloc_n;
                            tgt_q          <= ptr_q;
                            valid_q[ptr_q] <= 1'b0;
                            clr_q          <= '0;
                            state_q        <= CLEAR;
                        end else begin
                            alloc_err_q <= 1'b1;
                        end
                    end
                end
                CLEAR: begin
                    clr_q <= clr_q + 1'b1;
                    if (clr_q == CW'(WORDS - 1)) state_q <= GRANT;
                end
                GRANT: begin
                    alloc_valid_q  <= 1'b1;
                    alloc_id_q     <= 7'(tgt_q);
                    valid_q[tgt_q] <= 1'b1;
                    m_q[tgt_q]     <= am_q;
                    n_q[tgt_q]     <= an_q;
                    ptr_q          <= (ptr_q == SW'(SLOTS - 1)) ? '0 : ptr_q + 1'b1;
                    state_q        <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign alloc_valid = alloc_valid_q;
    assign alloc_id    = alloc_id_q;
    assign alloc_err   = alloc_err_q;
    assign busy        = busy_q;
    assign wr_err      = wr_err_q;
    assign rd_valid    = rd_valid_q;
    assign rd_data     = rd_data_q;
    assign rd_m        = rd_m_q;
    assign rd_n        = rd_n_q;
    assign rd_err      = rd_err_q;
    assign slot_valid  = valid_q;
endmodule

// File: tb/tb_matrix_store.sv
// Scoreboard bench for matrix_store: stimulus pushes expectations from a slot-level
// model, a negedge monitor pops and compares whenever the DUT strobes.
module tb_matrix_store;
    localparam int SLOTS   = 8;
    localparam int MAX_DIM = 5;
    localparam int DW      = 32;
    localparam int WORDS   = MAX_DIM * MAX_DIM;

    logic             clk = 1'b0;
    logic             rst;
    logic             alloc_req;
    logic [3:0]       alloc_m;
    logic [3:0]       alloc_n;
    logic             alloc_valid;
    logic [6:0]       alloc_id;
    logic             alloc_err;
    logic             busy;
    logic             mem_we;
    logic [6:0]       mem_id;
    logic [3:0]       mem_row;
    logic [3:0]       mem_col;
    logic [DW-1:0]    mem_data;
    logic             wr_err;
    logic             rd_req;
    logic [6:0]       rd_id;
    logic [3:0]       rd_row;
    logic [3:0]       rd_col;
    logic             rd_valid;
    logic [DW-1:0]    rd_data;
    logic [3:0]       rd_m;
    logic [3:0]       rd_n;
    logic             rd_err;
    logic [SLOTS-1:0] slot_valid;

    always #5 clk = ~clk;

    matrix_store #(.SLOTS(SLOTS), .MAX_DIM(MAX_DIM), .DW(DW)) dut (
        .clk(clk), .rst(rst),
        .alloc_req(alloc_req), .alloc_m(alloc_m), .alloc_n(alloc_n),
        .alloc_valid(alloc_valid), .alloc_id(alloc_id), .alloc_err(alloc_err), .busy(busy),
        .mem_we(mem_we), .mem_id(mem_id), .mem_row(mem_row), .mem_col(mem_col),
        .mem_data(mem_data), .wr_err(wr_err),
        .rd_req(rd_req), .rd_id(rd_id), .rd_row(rd_row), .rd_col(rd_col),
        .rd_valid(rd_valid), .rd_data(rd_data), .rd_m(rd_m), .rd_n(rd_n), .rd_err(rd_err),
        .slot_valid(slot_valid)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Slot-level reference model
    logic [DW-1:0] mdl_mem [SLOTS][WORDS];
    bit            mdl_valid [SLOTS];
    int            mdl_m [SLOTS];
    int            mdl_n [SLOTS];
    int            mdl_ptr;

    typedef struct {
        logic [DW-1:0] d;
        logic [3:0]    m;
        logic [3:0]    n;
        logic          e;
    } rd_t;

    rd_t exp_rd_q[$];
    int  exp_alloc_q[$];
    int  exp_aerr_q[$];
    int  exp_werr_q[$];

    function automatic bit mdl_ok(input int id, input int row, input int col);
        if (id < 0 || id >= SLOTS) return 1'b0;
        if (!mdl_valid[id]) return 1'b0;
        return (row < mdl_m[id]) && (col < mdl_n[id]);
    endfunction

    function automatic logic [SLOTS-1:0] mdl_bitmap();
        logic [SLOTS-1:0] b = '0;
        for (int i = 0; i < SLOTS; i++) b[i] = mdl_valid[i];
        return b;
    endfunction

    task automatic mdl_reset();
        for (int i = 0; i < SLOTS; i++) mdl_valid[i] = 1'b0;
        mdl_ptr = 0;
    endtask

    // Drive one cycle's worth of write/read inputs and record expectations.
    task automatic set_ops(input bit we, input int wid, input int wrow, input int wcol,
                           input logic [DW-1:0] wd,
                           input bit re, input int rid, input int rrow, input int rcol);
        rd_t e;
        if (re) begin
            if (mdl_ok(rid, rrow, rcol))
                e = '{d: mdl_mem[rid][rrow*MAX_DIM+rcol], m: 4'(mdl_m[rid]),
                      n: 4'(mdl_n[rid]), e: 1'b0};
            else
                e = '{d: '0, m: 4'd0, n: 4'd0, e: 1'b1};
            exp_rd_q.push_back(e);
        end
        if (we) begin
            if (mdl_ok(wid, wrow, wcol)) mdl_mem[wid][wrow*MAX_DIM+wcol] = wd;
            else exp_werr_q.push_back(1);
        end
        mem_we = we; mem_id = 7'(wid); mem_row = 4'(wrow); mem_col = 4'(wcol); mem_data = wd;
        rd_req = re; rd_id = 7'(rid); rd_row = 4'(rrow); rd_col = 4'(rcol);
    endtask

    task automatic op(input bit we, input int wid, input int wrow, input int wcol,
                      input logic [DW-1:0] wd,
                      input bit re, input int rid, input int rrow, input int rcol);
        set_ops(we, wid, wrow, wcol, wd, re, rid, rrow, rcol);
        @(posedge clk); #1;
        mem_we = 1'b0; rd_req = 1'b0;
    endtask

    task automatic do_alloc(input int m, input int n, input bit poke);
        bit good;
        int tgt, cyc, busy_hi;
        bit got;
        good = (m >= 1) && (m <= MAX_DIM) && (n >= 1) && (n <= MAX_DIM);
        if (!good) begin
            exp_aerr_q.push_back(1);
            alloc_req = 1'b1; alloc_m = 4'(m); alloc_n = 4'(n);
            @(posedge clk); #1;
            alloc_req = 1'b0;
            @(posedge clk); #1;
            chk("busy_after_rejected_alloc", 64'(busy), 64'd0);
            return;
        end
        tgt = mdl_ptr;
        mdl_valid[tgt] = 1'b0;
        exp_alloc_q.push_back(tgt);
        alloc_req = 1'b1; alloc_m = 4'(m); alloc_n = 4'(n);
        @(posedge clk); #1;
        alloc_req = 1'b0;
        cyc = 1; busy_hi = 0; got = 1'b0;
        while (cyc < 60 && !got) begin
            if (poke && cyc == 5) begin
                alloc_req = 1'b1; alloc_m = 4'd1; alloc_n = 4'd1;
                set_ops(1'b1, tgt, 0, 0, 32'hBAD0_0001, 1'b1, 5, 0, 0);
            end
            @(posedge clk); #1;
            alloc_req = 1'b0; mem_we = 1'b0; rd_req = 1'b0;
            cyc++;
            if (busy) busy_hi++;
            if (alloc_valid) got = 1'b1;
        end
        chk("grant_seen", 64'(got), 64'd1);
        chk("alloc_latency", 64'(cyc - 1), 64'(WORDS + 1));
        @(posedge clk); #1;
        chk("busy_after_grant", 64'(busy), 64'd0);
        chk("busy_cycles", 64'(busy_hi), 64'(WORDS + 1));
        for (int w = 0; w < WORDS; w++) mdl_mem[tgt][w] = '0;
        mdl_valid[tgt] = 1'b1;
        mdl_m[tgt] = m;
        mdl_n[tgt] = n;
        mdl_ptr = (mdl_ptr + 1) % SLOTS;
        chk("slot_valid", 64'(slot_valid), 64'(mdl_bitmap()));
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_alloc_valid"}, 64'(alloc_valid), 64'd0);
        chk({tag, "_alloc_id"},    64'(alloc_id),    64'd0);
        chk({tag, "_alloc_err"},   64'(alloc_err),   64'd0);
        chk({tag, "_busy"},        64'(busy),        64'd0);
        chk({tag, "_wr_err"},      64'(wr_err),      64'd0);
        chk({tag, "_rd_valid"},    64'(rd_valid),    64'd0);
        chk({tag, "_rd_data"},     64'(rd_data),     64'd0);
        chk({tag, "_rd_m"},        64'(rd_m),        64'd0);
        chk({tag, "_rd_n"},        64'(rd_n),        64'd0);
        chk({tag, "_rd_err"},      64'(rd_err),      64'd0);
        chk({tag, "_slot_valid"},  64'(slot_valid),  64'd0);
    endtask

    // Monitor: compares every DUT strobe against the head of its queue
    rd_t mon_e;
    always @(negedge clk) begin
        if (alloc_valid) begin
            if (exp_alloc_q.size() == 0) chk("unexpected_grant", 64'(alloc_valid), 64'd0);
            else chk("alloc_id", 64'(alloc_id), 64'(exp_alloc_q.pop_front()));
        end
        if (alloc_err) begin
            chk("alloc_err_expected", 64'(exp_aerr_q.size() > 0), 64'd1);
            if (exp_aerr_q.size() > 0) void'(exp_aerr_q.pop_front());
        end
        if (wr_err) begin
            chk("wr_err_expected", 64'(exp_werr_q.size() > 0), 64'd1);
            if (exp_werr_q.size() > 0) void'(exp_werr_q.pop_front());
        end
        if (rd_valid) begin
            if (exp_rd_q.size() == 0) begin
                chk("unexpected_rd_valid", 64'(rd_valid), 64'd0);
            end else begin
                mon_e = exp_rd_q.pop_front();
                chk("rd_data", 64'(rd_data), 64'(mon_e.d));
                chk("rd_m",    64'(rd_m),    64'(mon_e.m));
                chk("rd_n",    64'(rd_n),    64'(mon_e.n));
                chk("rd_err",  64'(rd_err),  64'(mon_e.e));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b0; alloc_req = 1'b0; alloc_m = '0; alloc_n = '0;
        mem_we = 1'b0; mem_id = '0; mem_row = '0; mem_col = '0; mem_data = '0;
        rd_req = 1'b0; rd_id = '0; rd_row = '0; rd_col = '0;
        mdl_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b1;
        @(posedge clk); #1;

        // First allocation, with an ignored request, a write to the clearing slot
        // and a read of an unallocated slot issued mid-CLEAR
        do_alloc(2, 3, 1'b1);
        chk("slot_valid_first", 64'(slot_valid), 64'h01);
        op(1'b0, 0, 0, 0, '0, 1'b1, 0, 1, 2);
        op(1'b1, 0, 1, 2, 32'd7, 1'b0, 0, 0, 0);
        op(1'b0, 0, 0, 0, '0, 1'b1, 0, 1, 2);
        op(1'b1, 0, 2, 2, 32'd99, 1'b0, 0, 0, 0);
        op(1'b1, 0, 1, 3, 32'd98, 1'b1, 0, 1, 2);
        op(1'b1, 0, 1, 2, 32'h1234, 1'b1, 0, 1, 2);
        op(1'b0, 0, 0, 0, '0, 1'b1, 0, 1, 2);
        op(1'b1, 9, 0, 0, 32'd5, 1'b1, 9, 0, 0);

        // Dimension rejects leave the pointer alone
        do_alloc(0, 3, 1'b0);
        do_alloc(2, 6, 1'b0);
        do_alloc(5, 5, 1'b0);
        for (int i = 0; i < 3; i++)
            do_alloc($urandom_range(1, MAX_DIM), $urandom_range(1, MAX_DIM), 1'b0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 4)
                do_alloc($urandom_range(0, 6), $urandom_range(0, 6), 1'(r & 1));
            else
                op(1'($urandom_range(0, 1)), $urandom_range(0, 8), $urandom_range(0, 5),
                   $urandom_range(0, 5), $urandom,
                   1'($urandom_range(0, 1)), $urandom_range(0, 8), $urandom_range(0, 5),
                   $urandom_range(0, 5));
        end

        // Reset during CLEAR aborts the allocation
        mdl_valid[mdl_ptr] = 1'b0;
        alloc_req = 1'b1; alloc_m = 4'd3; alloc_n = 4'd3;
        @(posedge clk); #1;
        alloc_req = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check_all_zero("abort");
        mdl_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        chk("slot_valid_after_abort", 64'(slot_valid), 64'd0);

        // Nine 1x1 allocations: IDs wrap and the ninth zero-fills slot 0
        do_alloc(1, 1, 1'b0);
        chk("first_id_after_reset", 64'(alloc_id), 64'd0);
        op(1'b1, 0, 0, 0, 32'hAB, 1'b0, 0, 0, 0);
        op(1'b0, 0, 0, 0, '0, 1'b1, 0, 0, 0);
        for (int i = 0; i < 7; i++) do_alloc(1, 1, 1'b0);
        chk("slot_valid_full", 64'(slot_valid), 64'hFF);
        do_alloc(1, 1, 1'b0);
        chk("ninth_grant_id", 64'(alloc_id), 64'd0);
        op(1'b0, 0, 0, 0, '0, 1'b1, 0, 0, 0);
        op(1'b0, 0, 0, 0, '0, 1'b1, 0, 1, 0);

        repeat (3) @(posedge clk);
        #1;
        chk("pending_grants",    64'(exp_alloc_q.size()), 64'd0);
        chk("pending_alloc_err", 64'(exp_aerr_q.size()),  64'd0);
        chk("pending_wr_err",    64'(exp_werr_q.size()),  64'd0);
        chk("pending_reads",     64'(exp_rd_q.size()),    64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/matrix_store.md
# matrix_store

Matrix storage and allocation responder for the matrix-calculator datapath. It serves the allocation handshake (`alloc_req` → `alloc_valid`/`alloc_id`) and the element-write port driven by matrix producers such as the LFSR generator and the UART input path. It also serves a registered element/metadata read port for the display and compute units. Each allocation claims a fixed-size slot, zero-fills it, records its dimensions, and returns the slot index as the matrix ID.

## Interface
- `SLOTS`, 8: number of matrix slots; IDs are 0..SLOTS-1.
- `MAX_DIM`, 5: maximum rows and maximum columns per matrix.
- `DW`, 32: element data width.
- `clk` in 1: single clock; all logic on the rising edge.
- `rst` in 1: reset, synchronous, active-low.
- `alloc_req` in 1: single-cycle allocation request.
- `alloc_m` in 4: requested rows.
- `alloc_n` in 4: requested columns.
- `alloc_valid` out 1: one-cycle grant pulse.
- `alloc_id` out 7: granted ID; held until the next grant.
- `alloc_err` out 1: one-cycle pulse when a request is rejected.
- `busy` out 1: high when not in IDLE.
- `mem_we` in 1: element write strobe.
- `mem_id` in 7: write target ID.
- `mem_row` in 4: write target row.
- `mem_col` in 4: write target column.
- `mem_data` in DW: element value to write.
- `wr_err` out 1: one-cycle pulse when a write is dropped.
- `rd_req` in 1: read request.
- `rd_id` in 7: read target ID.
- `rd_row` in 4: read target row.
- `rd_col` in 4: read target column.
- `rd_valid` out 1: one-cycle pulse with read results.
- `rd_data` out DW: element value read.
- `rd_m` out 4: rows of the matrix read.
- `rd_n` out 4: columns of the matrix read.
- `rd_err` out 1: read was rejected.
- `slot_valid` out SLOTS: bitmap of allocated slots.

## Operation
- Storage is SLOTS×MAX_DIM² words of DW bits.
- Address is `id*MAX_DIM*MAX_DIM + row*MAX_DIM + col`, computed at 10-bit width and independent of the matrix's own n.
- Per slot the block keeps a valid bit, `m[3:0]` and `n[3:0]`.
- `alloc_ptr` has width clog2(SLOTS) and points to the next slot to grant; it wraps SLOTS-1→0.
- When all slots are valid, the next grant overwrites the oldest slot (the one at `alloc_ptr`).
- FSM states: IDLE, CLEAR, GRANT.
- IDLE, `alloc_req`=1, with 1≤`alloc_m`≤MAX_DIM and 1≤`alloc_n`≤MAX_DIM:
  - latch m, n and the target slot (`alloc_ptr`);
  - clear the target slot's valid bit;
  - go to CLEAR with `clr_idx`=0.
- IDLE, `alloc_req`=1, dimensions out of range: pulse `alloc_err` on the next cycle, stay in IDLE, leave `alloc_ptr` unchanged.
- CLEAR: write 0 to word `clr_idx` of the target slot each cycle. After index MAX_DIM²−1 has been written, go to GRANT. The whole slot is cleared regardless of m and n.
- GRANT, one cycle:
  - pulse `alloc_valid`;
  - `alloc_id` = target slot, zero-extended to 7 bits;
  - set the slot's valid bit and store its m, n;
  - `alloc_ptr`++;
  - return to IDLE.
- `alloc_req` while `busy`=1 is ignored: no error and no queueing.
- A write is accepted when `mem_we`=1, `mem_id`<SLOTS, the slot is valid, `mem_row`<m and `mem_col`<n. Accepted writes are stored in the same cycle's edge.
- Any write failing those checks is dropped and `wr_err` pulses the next cycle.
- Writes to the slot currently being cleared are dropped (that slot is invalid) and raise `wr_err`.
- The CLEAR write port and the external write port are independent. An accepted external write can only target a different slot, so no conflict exists.
- Read: a `rd_req` sampled at edge t gives outputs at edge t+1.
  - `rd_valid`=1 for one cycle.
  - `rd_data` is the stored word, or 0 if rejected.
  - `rd_m`/`rd_n` are the slot's dimensions, or 0 if rejected.
  - `rd_err`=1 when the ID is out of range, the slot is invalid, or row/col is out of bounds.
- A read of an address written on the same edge returns the old data (read-before-write).
- Reads are accepted in every FSM state.

## Timing
- Reset (`rst`=0 at an edge), all outputs 0:
  - `alloc_valid`, `alloc_id`, `alloc_err`, `busy`, `wr_err`, `rd_valid`, `rd_data`, `rd_m`, `rd_n`, `rd_err` = 0;
  - `slot_valid` = 0;
  - FSM = IDLE, `alloc_ptr` = 0.
- Memory contents are not reset. Stale data is unreachable until re-allocated, and re-allocation zero-fills the slot.
- Reset asserted mid-CLEAR aborts the allocation. No grant is issued and the partially cleared slot stays invalid.
- Allocation latency: `alloc_req` sampled at edge t gives `busy`=1 from t+1 and `alloc_valid` at edge t+MAX_DIM²+1 (t+26 with defaults). `busy` falls at t+MAX_DIM²+2.
- All error and valid strobes are registered one-cycle pulses.

## Test plan
- Reset, then `alloc_req` with m=2, n=3 → `busy` for 26 cycles, then `alloc_valid` with `alloc_id`=0, `slot_valid`=8'h01. Reading (0,1,2) gives `rd_data`=0, `rd_m`=2, `rd_n`=3, `rd_err`=0.
- Write id 0, row 1, col 2, data 7, then read the same address → `rd_data`=7. Writing row 2 (≥m) gives `wr_err` and a read of the old location is unchanged.
- `alloc_req` with m=0, then with n=6 → `alloc_err` pulses each time, no grant, `alloc_ptr` still 0.
- Nine consecutive 1×1 allocations → IDs 0..7 then 0. The ninth grant zero-fills slot 0, so previously written data reads back 0.
- `alloc_req` during CLEAR → ignored. A write to the slot being cleared → `wr_err`. A read of an unallocated id 5 → `rd_err`=1, `rd_data`=0.
- Assert `rst` low at cycle 10 of CLEAR → no `alloc_valid`, all outputs 0, and a subsequent allocation returns ID 0.
